// File: rtl/tape_pkg.sv
// Shared definitions for the interpreter data tape.
// Contents:
//   tape_op_t     3-bit operation code, plus the OP_* constants
//   tape_state_e  sequencer state (idle / clear sweep)
package tape_pkg;

    typedef logic [2:0] tape_op_t;

    localparam tape_op_t OP_NOP   = 3'd0;
    localparam tape_op_t OP_INC   = 3'd1;
    localparam tape_op_t OP_DEC   = 3'd2;
    localparam tape_op_t OP_RIGHT = 3'd3;
    localparam tape_op_t OP_LEFT  = 3'd4;
    localparam tape_op_t OP_LOAD  = 3'd5;
    localparam tape_op_t OP_CLEAR = 3'd6;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StSweep = 1'b1
    } tape_state_e;

endpackage

// File: rtl/tape_cell_alu.sv
// Next-value logic for a single tape cell.
// Ports:
//   op          operation code; only INC, DEC and LOAD change the value
//   value       current cell contents
//   load_value  value written by LOAD
//   result      new cell contents (equals value for every other code)
// Arithmetic wraps modulo 2^c_width.
module tape_cell_alu
    import tape_pkg::*;
#(
    parameter int unsigned c_width = 8
) (
    input  tape_op_t           op,
    input  logic [c_width-1:0] value,
    input  logic [c_width-1:0] load_value,
    output logic [c_width-1:0] result
);

    always_comb begin
        result = value;
        case (op)
            OP_INC:  result = value + c_width'(1);
            OP_DEC:  result = value - c_width'(1);
            OP_LOAD: result = load_value;
            default: result = value;
        endcase
    end

endmodule

// File: rtl/tape_register_file.sv
// Interpreter data tape: c_depth cells of c_width bits with an internal pointer.
// One operation per cycle is accepted through i_valid/o_ready. OP_CLEAR starts a
// sweep that zeroes one cell per cycle (index 0 upwards) and then parks the
// pointer at 0; the block is busy for exactly c_depth cycles.
// Ports:
//   i_clock    rising-edge clock
//   i_reset    asynchronous active-high reset (clears all cells and the pointer)
//   i_valid    operation request
//   i_op       operation code (tape_pkg OP_*)
//   i_data     value for OP_LOAD
//   o_ready    high when an operation can be accepted (idle)
//   o_data     contents of the cell under the pointer
//   o_pointer  current pointer
//   o_zero     o_data == 0
// All outputs depend on stored state only.
module tape_register_file
    import tape_pkg::*;
#(
    parameter  int unsigned c_width     = 8,
    parameter  int unsigned c_depth     = 16,
    localparam int unsigned c_ptr_width = (c_depth > 1) ? $clog2(c_depth) : 1
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic [2:0]             i_op,
    input  logic [c_width-1:0]     i_data,
    output logic                   o_ready,
    output logic [c_width-1:0]     o_data,
    output logic [c_ptr_width-1:0] o_pointer,
    output logic                   o_zero
);

    localparam logic [c_ptr_width-1:0] ptr_last = c_ptr_width'(c_depth - 1);
    localparam logic [c_ptr_width-1:0] ptr_one  = c_ptr_width'(1);

    // Flops rather than RAM: reset has to clear every cell at once.
    logic [c_width-1:0]     cells_q [c_depth];
    logic [c_width-1:0]     cells_d [c_depth];
    logic [c_ptr_width-1:0] ptr_q, ptr_d;
    logic [c_ptr_width-1:0] sweep_q, sweep_d;
    tape_state_e            state_q, state_d;

    logic                   accept;
    tape_op_t               alu_op;
    logic [c_width-1:0]     cur_cell;
    logic [c_width-1:0]     alu_result;

    assign cur_cell = cells_q[ptr_q];
    assign accept   = i_valid && (state_q == StIdle);
    // Only accepted requests reach the ALU, so an unaccepted op can never
    // modify a cell even if the write logic below changes.
    assign alu_op   = accept ? tape_op_t'(i_op) : OP_NOP;

    tape_cell_alu #(
        .c_width (c_width)
    ) u_alu (
        .op         (alu_op),
        .value      (cur_cell),
        .load_value (i_data),
        .result     (alu_result)
    );

    always_comb begin
        cells_d = cells_q;
        ptr_d   = ptr_q;
        sweep_d = sweep_q;
        state_d = state_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    case (tape_op_t'(i_op))
                        OP_INC, OP_DEC, OP_LOAD: begin
                            cells_d[ptr_q] = alu_result;
                        end
                        OP_RIGHT: begin
                            ptr_d = (ptr_q == ptr_last) ? '0 : ptr_q + ptr_one;
                        end
                        OP_LEFT: begin
                            ptr_d = (ptr_q == '0) ? ptr_last : ptr_q - ptr_one;
                        end
                        OP_CLEAR: begin
                            state_d = StSweep;
                            sweep_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            StSweep: begin
                cells_d[sweep_q] = '0;
                if (sweep_q == ptr_last) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + ptr_one;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < int'(c_depth); i++) begin
                cells_q[i] <= '0;
            end
            ptr_q   <= '0;
            sweep_q <= '0;
            state_q <= StIdle;
        end else begin
            cells_q <= cells_d;
            ptr_q   <= ptr_d;
            sweep_q <= sweep_d;
            state_q <= state_d;
        end
    end

    assign o_ready   = (state_q == StIdle);
    assign o_data    = cur_cell;
    assign o_pointer = ptr_q;
    assign o_zero    = (cur_cell == '0);

endmodule

// File: tb/tb_tape_register_file.sv
// Bench for tape_register_file: a default instance (8 x 16) and a small one (4 x 5).
module tb_tape_register_file;

    localparam logic [2:0] NOP   = 3'd0;
    localparam logic [2:0] INC   = 3'd1;
    localparam logic [2:0] DEC   = 3'd2;
    localparam logic [2:0] RIGHT = 3'd3;
    localparam logic [2:0] LEFT  = 3'd4;
    localparam logic [2:0] LOAD  = 3'd5;
    localparam logic [2:0] CLEAR = 3'd6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       valid = 1'b0;
    logic [2:0] op = NOP;
    logic [7:0] data = '0;
    logic       ready;
    logic [7:0] dout;
    logic [3:0] ptr;
    logic       zero;

    logic       valid_s = 1'b0;
    logic [2:0] op_s = NOP;
    logic [3:0] data_s = '0;
    logic       ready_s;
    logic [3:0] dout_s;
    logic [2:0] ptr_s;
    logic       zero_s;

    int n_checks = 0;
    int n_fail = 0;

    // Reference tape for the random test.
    int m_cells [16];
    int m_ptr;

    always #5 clk = ~clk;

    tape_register_file dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_valid   (valid),
        .i_op      (op),
        .i_data    (data),
        .o_ready   (ready),
        .o_data    (dout),
        .o_pointer (ptr),
        .o_zero    (zero)
    );

    tape_register_file #(
        .c_width (4),
        .c_depth (5)
    ) dut_s (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_valid   (valid_s),
        .i_op      (op_s),
        .i_data    (data_s),
        .o_ready   (ready_s),
        .o_data    (dout_s),
        .o_pointer (ptr_s),
        .o_zero    (zero_s)
    );

    // Present one request for one edge, then sample just after that edge.
    task automatic step(input logic [2:0] o, input logic [7:0] d);
        @(negedge clk);
        valid = 1'b1;
        op    = o;
        data  = d;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic step_s(input logic [2:0] o);
        @(negedge clk);
        valid_s = 1'b1;
        op_s    = o;
        @(posedge clk);
        #1;
        valid_s = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b1 || dout !== 8'd0 || ptr !== 4'd0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_held: ready=%b data=%0d ptr=%0d zero=%b, want 1/0/0/1",
                     ready, dout, ptr, zero);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b1 || dout !== 8'd0 || ptr !== 4'd0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b data=%0d ptr=%0d zero=%b, want 1/0/0/1",
                     ready, dout, ptr, zero);
        end
        n_checks++;
        if (ready_s !== 1'b1 || dout_s !== 4'd0 || ptr_s !== 3'd0 || zero_s !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_small: ready=%b data=%0d ptr=%0d zero=%b, want 1/0/0/1",
                     ready_s, dout_s, ptr_s, zero_s);
        end
    endtask

    task automatic test_wrap();
        step(DEC, 8'h00);
        n_checks++;
        if (dout !== 8'd255 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL dec_wrap: data=%0d zero=%b, want 255/0", dout, zero);
        end
        step(INC, 8'h00);
        n_checks++;
        if (dout !== 8'd0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL inc_wrap: data=%0d zero=%b, want 0/1", dout, zero);
        end
        step(LEFT, 8'h00);
        n_checks++;
        if (ptr !== 4'd15) begin
            n_fail++;
            $display("FAIL left_wrap: ptr=%0d, want 15", ptr);
        end
        step(RIGHT, 8'h00);
        n_checks++;
        if (ptr !== 4'd0) begin
            n_fail++;
            $display("FAIL right_wrap: ptr=%0d, want 0", ptr);
        end
    endtask

    task automatic test_independent();
        step(LOAD, 8'h5A);
        step(RIGHT, 8'h00);
        step(LOAD, 8'h11);
        step(LEFT, 8'h00);
        n_checks++;
        if (dout !== 8'h5A || ptr !== 4'd0) begin
            n_fail++;
            $display("FAIL cell0_kept: data=%h ptr=%0d, want 5a/0", dout, ptr);
        end
        step(RIGHT, 8'h00);
        n_checks++;
        if (dout !== 8'h11 || ptr !== 4'd1) begin
            n_fail++;
            $display("FAIL cell1_kept: data=%h ptr=%0d, want 11/1", dout, ptr);
        end
        // Request held low: nothing may change.
        @(negedge clk);
        valid = 1'b0;
        op    = INC;
        repeat (3) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (dout !== 8'h11 || ptr !== 4'd1) begin
                n_fail++;
                $display("FAIL idle_no_change: data=%h ptr=%0d, want 11/1", dout, ptr);
            end
        end
        op = NOP;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        // Inputs change every cycle with valid held high throughout.
        @(negedge clk);
        valid = 1'b1;
        op    = INC;
        @(negedge clk);
        op = RIGHT;
        @(negedge clk);
        op = INC;
        @(negedge clk);
        op = INC;
        @(negedge clk);
        valid = 1'b0;
        op    = NOP;
        n_checks++;
        if (dout !== 8'd2 || ptr !== 4'd1) begin
            n_fail++;
            $display("FAIL b2b_cell1: data=%0d ptr=%0d, want 2/1", dout, ptr);
        end
        step(LEFT, 8'h00);
        n_checks++;
        if (dout !== 8'd1 || ptr !== 4'd0) begin
            n_fail++;
            $display("FAIL b2b_cell0: data=%0d ptr=%0d, want 1/0", dout, ptr);
        end
    endtask

    task automatic test_sweep();
        int low;
        int j;
        int bad_data;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            step(LOAD, 8'(i + 1));
            step(RIGHT, 8'h00);
        end
        repeat (7) step(RIGHT, 8'h00);
        n_checks++;
        if (ptr !== 4'd7 || dout !== 8'd8) begin
            n_fail++;
            $display("FAIL sweep_setup: ptr=%0d data=%0d, want 7/8", ptr, dout);
        end
        step(CLEAR, 8'h00);
        // Keep requesting INC during the sweep; all must be ignored.
        valid    = 1'b1;
        op       = INC;
        low      = 0;
        j        = 0;
        bad_data = 0;
        while (ready !== 1'b1 && j < 40) begin
            low++;
            // After j sweep edges cells 0..j-1 are zero; the pointer stays at 7.
            if (dout !== ((j >= 8) ? 8'd0 : 8'd8)) bad_data++;
            @(posedge clk);
            #1;
            j++;
        end
        valid = 1'b0;
        op    = NOP;
        n_checks++;
        if (low !== 16) begin
            n_fail++;
            $display("FAIL sweep_busy_cycles: got %0d, want 16", low);
        end
        n_checks++;
        if (bad_data !== 0) begin
            n_fail++;
            $display("FAIL sweep_data_track: %0d bad samples, want 0", bad_data);
        end
        n_checks++;
        if (ptr !== 4'd0) begin
            n_fail++;
            $display("FAIL sweep_ptr: ptr=%0d, want 0", ptr);
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (dout !== 8'd0 || zero !== 1'b1) begin
                n_fail++;
                $display("FAIL sweep_cell_%0d: data=%0d zero=%b, want 0/1", i, dout, zero);
            end
            step(RIGHT, 8'h00);
        end
    endtask

    task automatic test_reset_mid_sweep();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            step(LOAD, 8'(8'hA0 + i));
            step(RIGHT, 8'h00);
        end
        repeat (9) step(RIGHT, 8'h00);
        step(CLEAR, 8'h00);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (ready !== 1'b1 || ptr !== 4'd0 || dout !== 8'd0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL midsweep_reset: ready=%b ptr=%0d data=%0d zero=%b, want 1/0/0/1",
                     ready, ptr, dout, zero);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (dout !== 8'd0) begin
                n_fail++;
                $display("FAIL midsweep_cell_%0d: data=%0d, want 0", i, dout);
            end
            step(RIGHT, 8'h00);
        end
        step(INC, 8'h00);
        n_checks++;
        if (dout !== 8'd1 || ptr !== 4'd0) begin
            n_fail++;
            $display("FAIL midsweep_inc: data=%0d ptr=%0d, want 1/0", dout, ptr);
        end
    endtask

    task automatic test_random();
        logic [2:0] r_op;
        logic [7:0] r_data;
        logic       r_valid;
        int         exp;
        apply_reset();
        for (int i = 0; i < 16; i++) m_cells[i] = 0;
        m_ptr = 0;
        for (int n = 0; n < 400; n++) begin
            r_op    = 3'($urandom_range(0, 7));
            if (r_op == CLEAR) r_op = 3'd7;
            r_data  = 8'($urandom);
            r_valid = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            valid = r_valid;
            op    = r_op;
            data  = r_data;
            @(posedge clk);
            #1;
            if (r_valid) begin
                case (r_op)
                    INC:     m_cells[m_ptr] = (m_cells[m_ptr] + 1) % 256;
                    DEC:     m_cells[m_ptr] = (m_cells[m_ptr] + 255) % 256;
                    RIGHT:   m_ptr = (m_ptr + 1) % 16;
                    LEFT:    m_ptr = (m_ptr + 15) % 16;
                    LOAD:    m_cells[m_ptr] = int'(r_data);
                    default: ;
                endcase
            end
            exp = m_cells[m_ptr];
            n_checks++;
            if (int'(dout) != exp || int'(ptr) != m_ptr || zero !== (exp == 0)
                || ready !== 1'b1) begin
                n_fail++;
                $display("FAIL random_%0d: op=%0d v=%b data=%0d ptr=%0d zero=%b rdy=%b, want %0d/%0d/%b/1",
                         n, r_op, r_valid, dout, ptr, zero, ready, exp, m_ptr, exp == 0);
            end
        end
        valid = 1'b0;
        op    = NOP;
    endtask

    task automatic test_small_params();
        int low;
        int j;
        apply_reset();
        for (int i = 1; i <= 5; i++) begin
            step_s(RIGHT);
            n_checks++;
            if (int'(ptr_s) != i % 5) begin
                n_fail++;
                $display("FAIL small_right_%0d: ptr=%0d, want %0d", i, ptr_s, i % 5);
            end
        end
        for (int i = 1; i <= 16; i++) step_s(INC);
        n_checks++;
        if (dout_s !== 4'd0 || zero_s !== 1'b1) begin
            n_fail++;
            $display("FAIL small_inc_wrap: data=%0d zero=%b, want 0/1", dout_s, zero_s);
        end
        step_s(INC);
        step_s(LEFT);
        n_checks++;
        if (ptr_s !== 3'd4) begin
            n_fail++;
            $display("FAIL small_left_wrap: ptr=%0d, want 4", ptr_s);
        end
        step_s(INC);
        step_s(CLEAR);
        low = 0;
        j   = 0;
        while (ready_s !== 1'b1 && j < 20) begin
            low++;
            @(posedge clk);
            #1;
            j++;
        end
        n_checks++;
        if (low !== 5) begin
            n_fail++;
            $display("FAIL small_clear_cycles: got %0d, want 5", low);
        end
        n_checks++;
        if (ptr_s !== 3'd0 || dout_s !== 4'd0) begin
            n_fail++;
            $display("FAIL small_clear_state: ptr=%0d data=%0d, want 0/0", ptr_s, dout_s);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_wrap();
        test_independent();
        test_back_to_back();
        test_sweep();
        test_reset_mid_sweep();
        test_random();
        test_small_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tape_register_file.md
# tape_register_file

Parametrised, multi-cell successor to the single enable-gated data register: a bank of `c_depth` cells of `c_width` bits with an internal cell pointer, supporting in-place increment, decrement, load, pointer move and a multi-cycle clear sweep. It holds the interpreter's data tape. The core issues one operation per cycle through a valid/ready handshake and reads the current cell, pointer and zero flag combinationally.

## Interface
- `c_width`, 8, bits per cell
- `c_depth`, 16, number of cells, ≥2, need not be a power of two
- `c_ptr_width`, derived as max(1, clog2(`c_depth`)), pointer width; not overridable
- `i_clock`  in  1  clock; all state changes on rising edge only
- `i_reset`  in  1  asynchronous, active-high reset
- `i_valid`  in  1  operation request
- `i_op`  in  3  operation code (see Operation)
- `i_data`  in  `c_width`  load value for OP_LOAD
- `o_ready`  out  1  block accepts an operation this cycle
- `o_data`  out  `c_width`  contents of the cell at the pointer
- `o_pointer`  out  `c_ptr_width`  current pointer
- `o_zero`  out  1  high when `o_data` == 0

## Operation
- Accept when `i_valid && o_ready` at a rising edge. Otherwise no state changes, except sweep progress.
- OP_NOP (0): no effect.
- OP_INC (1): cell[ptr] ← cell[ptr]+1 mod 2^`c_width`. Max wraps to 0.
- OP_DEC (2): cell[ptr] ← cell[ptr]−1 mod 2^`c_width`. 0 wraps to all-ones.
- OP_RIGHT (3): ptr ← ptr+1. `c_depth`−1 wraps to 0.
- OP_LEFT (4): ptr ← ptr−1. 0 wraps to `c_depth`−1.
- OP_LOAD (5): cell[ptr] ← `i_data`.
- OP_CLEAR (6): enter SWEEP.
- Codes 7: treated as NOP.
- FSM states: IDLE and SWEEP.
  - IDLE: `o_ready`=1.
  - OP_CLEAR accepted in IDLE → SWEEP, sweep index ← 0.
  - SWEEP: `o_ready`=0. `i_valid` and `i_op` are ignored. One cell is zeroed per cycle, at index 0, 1, …, `c_depth`−1.
  - After the edge that zeroes index `c_depth`−1: go to IDLE and set ptr ← 0.
- Reset, asserted at any time including mid-sweep: all cells 0, ptr 0, state IDLE, immediately and asynchronously.
- Reset values: `o_data`=0, `o_pointer`=0, `o_zero`=1, `o_ready`=1.

## Timing
- Single-cycle ops: effect is visible on outputs right after the accepting edge. Latency is 1 edge.
- Outputs are combinational from stored state: pointer, cells, FSM. There is no input-to-output combinational path.
- Back-to-back ops every cycle are supported.
  - Example: INC then RIGHT then INC touches two different cells.
- OP_CLEAR:
  - `o_ready` is low from the edge after acceptance for exactly `c_depth` cycles.
  - `o_ready` is high again after the final sweep edge.
  - Total occupancy is `c_depth` cycles.
- During SWEEP, `o_data`/`o_zero` track the cell at the unchanged ptr, which goes to 0 when the sweep reaches it.
- Reset release: first op can be accepted at the first rising edge with `i_reset` low.

## Structure
- Package `tape_pkg`:
  - op code constants OP_NOP…OP_CLEAR, 3-bit op type
  - FSM state encoding (IDLE, SWEEP)
- Sub-module `tape_cell_alu`: combinational next-cell-value for INC/DEC/LOAD/hold, parametrised on `c_width`.
- The top module owns storage, the pointer, the sweep counter and the FSM.
- Storage is flops with async clear, not inferred RAM, because reset must clear every cell.

## Test plan
- Reset, then check the idle outputs:
  - Reset held, then released → `o_data`=0, `o_pointer`=0, `o_zero`=1, `o_ready`=1.
- Wrap-around, default parameters:
  - DEC at cell 0 → `o_data`=255, `o_zero`=0.
  - INC → `o_data`=0.
  - LEFT at ptr 0 → `o_pointer`=15.
  - RIGHT → 0.
- Independent cells:
  - LOAD 0x5A, RIGHT, LOAD 0x11, LEFT → `o_data`=0x5A.
  - RIGHT → 0x11.
  - `i_valid`=0 with `i_op`=INC for 3 cycles → no change.
- Sweep:
  - Load cells 0..15 with nonzero values, ptr at 7, then CLEAR:
    - `o_ready` is low for exactly 16 cycles.
    - INC requests during the sweep are ignored.
  - Afterwards all cells read 0 and `o_pointer`=0.
- Reset mid-sweep:
  - Assert `i_reset` 5 cycles into CLEAR → immediately `o_ready`=1, all cells 0.
  - Next INC → `o_data`=1.
- Parameter sweep:
  - `c_width`=4, `c_depth`=5: RIGHT ×5 returns `o_pointer`=0.
  - INC ×16 returns `o_data`=0.
  - CLEAR occupies 5 cycles.
